// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
//   It merges four event sources into per-stage write-enable and flush controls:
//   data-memory wait, multi-cycle mul/div occupancy of EX, taken branch/jump
//   redirect from EX, and load-use hazard. The list is in priority order.
//   It also owns the mul/div hold counter and a saturating stall counter.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   id_rs1_addr/id_rs2_addr     source registers of the instruction in ID
//   id_rs1_used/id_rs2_used     ID instruction actually reads rs1/rs2
//   ex_mem_read, ex_rd_addr     EX instruction is a load, and its destination
//   ex_branch_taken             EX redirects (taken branch or jump)
//   ex_muldiv                   EX holds a multi-cycle mul/div
//   dm_req, dm_ready            MEM data access request / completion
//   pc_we..memwb_we             per-stage register update enables
//   ifid_flush..exmem_flush     per-stage bubble insertion
//   muldiv_done                 pulse when the mul/div result leaves EX
//   stall_cycles                saturating count of cycles with pc_we=0
module pipeline_stall_ctrl #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_flush,
    output logic             memwb_we,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MW       = $clog2(MULDIV_LAT) + 1;
    localparam bit          MD_MULTI = (MULDIV_LAT > 1);
    // The first occupancy cycle is spent in RUN, so the counter covers the rest.
    localparam logic [MW-1:0] MD_LOAD = MD_MULTI ? MW'(MULDIV_LAT - 2) : '0;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [MW-1:0] md_cnt, md_cnt_n;
    logic          freeze;
    logic          lu_hit;

    assign freeze = dm_req & ~dm_ready;
    assign lu_hit = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_n;
            md_cnt <= md_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        md_cnt_n    = md_cnt;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        exmem_flush = 1'b0;
        memwb_we    = 1'b1;
        muldiv_done = 1'b0;

        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (freeze) begin
            // Whole pipe holds; a pending redirect stays in EX until release.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (state == MULDIV) begin
            if (md_cnt == '0) begin
                muldiv_done = 1'b1;
                state_n     = RUN;
            end else begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_flush = 1'b1;
                md_cnt_n    = md_cnt - 1'b1;
            end
        end else if (ex_muldiv && MD_MULTI) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            md_cnt_n    = MD_LOAD;
            state_n     = MULDIV;
        end else begin
            // Single-cycle mul/div: result leaves EX immediately.
            muldiv_done = ex_muldiv;
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_hit) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_we && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
